// File: rtl/snake_engine_if.sv
// Button/display bundle between the board I/O and the snake core.
interface snake_engine_if #(
    parameter int unsigned GRID_W  = 8,
    parameter int unsigned GRID_H  = 8,
    parameter int unsigned SCORE_W = 7,
    parameter int unsigned LEN_W   = 5
);
    logic               i_Start;
    logic [3:0]         i_Push;
    logic [GRID_H-1:0]  o_Row;
    logic [GRID_W-1:0]  o_Col;
    logic [SCORE_W-1:0] o_Score;
    logic [LEN_W-1:0]   o_Len;
    logic [1:0]         o_State;
    logic               o_GameOver;

    modport master (output i_Start, i_Push,
                    input  o_Row, o_Col, o_Score, o_Len, o_State, o_GameOver);
    modport slave  (input  i_Start, i_Push,
                    output o_Row, o_Col, o_Score, o_Len, o_State, o_GameOver);
endinterface

// File: rtl/snake_engine.sv
// Parametrised snake game core with LFSR food placement and row-scanned matrix output.
// Define SNAKE_WRAP_EN to make the snake wrap at the grid edges instead of dying.
module snake_engine #(
    parameter int unsigned GRID_W   = 8,
    parameter int unsigned GRID_H   = 8,
    parameter int unsigned MAX_LEN  = 16,
    parameter int unsigned TICK_DIV = 4000000,
    parameter int unsigned SCORE_W  = 7
) (
    input logic          i_Clk,
    input logic          i_Rst,
    snake_engine_if.slave bus
);
    localparam int unsigned XW = $clog2(GRID_W);
    localparam int unsigned YW = $clog2(GRID_H);
    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned CW = $clog2(TICK_DIV);

    localparam logic [1:0] D_UP    = 2'd0;
    localparam logic [1:0] D_DOWN  = 2'd1;
    localparam logic [1:0] D_LEFT  = 2'd2;
    localparam logic [1:0] D_RIGHT = 2'd3;
    localparam logic [GRID_H-1:0] ROW_ONE = {{(GRID_H-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FOOD = 2'd2, OVER = 2'd3} state_t;

    state_t             state;
    logic [XW-1:0]      seg_x [MAX_LEN];
    logic [YW-1:0]      seg_y [MAX_LEN];
    logic [LW-1:0]      len;
    logic [1:0]         dir, pend;
    logic [XW-1:0]      food_x;
    logic [YW-1:0]      food_y;
    logic [SCORE_W-1:0] score;
    logic [CW-1:0]      cnt;
    logic [15:0]        lfsr;
    logic [YW-1:0]      row;
    logic [GRID_H-1:0]  row_q;
    logic [GRID_W-1:0]  col_q;
    logic               over_q;

    logic               tick_c, btn_vld_c, oob_c, eat_c, hit_c, cand_hit_c;
    logic [1:0]         btn_dir_c;
    logic [XW-1:0]      nx_c, cand_x_c;
    logic [YW-1:0]      ny_c, cand_y_c;
    logic [GRID_W-1:0]  col_c;

    assign tick_c   = (state == RUN) && (cnt == CW'(TICK_DIV - 1));
    assign cand_x_c = lfsr[XW-1:0];
    assign cand_y_c = lfsr[8 +: YW];
    assign eat_c    = (nx_c == food_x) && (ny_c == food_y);

    // Lowest-index pressed button wins.
    always_comb begin
        btn_vld_c = 1'b0;
        btn_dir_c = D_UP;
        for (int i = 3; i >= 0; i--) begin
            if (!bus.i_Push[i]) begin
                btn_vld_c = 1'b1;
                btn_dir_c = 2'(i);
            end
        end
    end

    // Next head position; the move uses the direction being committed on this tick.
    always_comb begin
        nx_c  = seg_x[0];
        ny_c  = seg_y[0];
        oob_c = 1'b0;
        case (pend)
            D_UP:    begin ny_c = seg_y[0] - YW'(1); oob_c = (seg_y[0] == '0); end
            D_DOWN:  begin ny_c = seg_y[0] + YW'(1); oob_c = (seg_y[0] == YW'(GRID_H - 1)); end
            D_LEFT:  begin nx_c = seg_x[0] - XW'(1); oob_c = (seg_x[0] == '0); end
            default: begin nx_c = seg_x[0] + XW'(1); oob_c = (seg_x[0] == XW'(GRID_W - 1)); end
        endcase
`ifdef SNAKE_WRAP_EN
        oob_c = 1'b0;
`endif
    end

    // The tail cell vacates on a plain move, so it only counts when the snake grows.
    always_comb begin
        hit_c      = 1'b0;
        cand_hit_c = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i > 0 && ((LW'(i) < len - LW'(1)) || (eat_c && (LW'(i) < len))) &&
                seg_x[i] == nx_c && seg_y[i] == ny_c)
                hit_c = 1'b1;
            if ((LW'(i) < len) && seg_x[i] == cand_x_c && seg_y[i] == cand_y_c)
                cand_hit_c = 1'b1;
        end
    end

    always_comb begin
        col_c = '0;
        for (int x = 0; x < GRID_W; x++) begin
            if (food_x == XW'(x) && food_y == row) col_c[x] = 1'b1;
            for (int i = 0; i < MAX_LEN; i++)
                if ((LW'(i) < len) && seg_x[i] == XW'(x) && seg_y[i] == row) col_c[x] = 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        // Reset and restart-from-OVER share the game initialisation.
        if (!i_Rst || (state == OVER && bus.i_Start)) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= (i < 3) ? XW'(2 - i) : '0;
                seg_y[i] <= '0;
            end
            len    <= LW'(3);
            dir    <= D_RIGHT;
            pend   <= D_RIGHT;
            food_x <= XW'(GRID_W - 2);
            food_y <= YW'(GRID_H - 2);
            score  <= '0;
            cnt    <= '0;
            over_q <= 1'b0;
            state  <= i_Rst ? RUN : IDLE;
        end else begin
            if (btn_vld_c && (btn_dir_c != (dir ^ 2'b01))) pend <= btn_dir_c;
            case (state)
                IDLE: if (bus.i_Start) begin
                    state <= RUN;
                    cnt   <= '0;
                end
                RUN: begin
                    cnt <= tick_c ? '0 : cnt + CW'(1);
                    if (tick_c) begin
                        dir <= pend;
                        if (oob_c || hit_c) begin
                            state  <= OVER;
                            over_q <= 1'b1;
                        end else begin
                            for (int i = MAX_LEN - 1; i > 0; i--) begin
                                seg_x[i] <= seg_x[i-1];
                                seg_y[i] <= seg_y[i-1];
                            end
                            seg_x[0] <= nx_c;
                            seg_y[0] <= ny_c;
                            if (eat_c) begin
                                if (len != LW'(MAX_LEN)) len <= len + LW'(1);
                                if (score != '1) score <= score + SCORE_W'(1);
                                state <= FOOD;
                            end
                        end
                    end
                end
                FOOD: if (!cand_hit_c) begin
                    food_x <= cand_x_c;
                    food_y <= cand_y_c;
                    cnt    <= '0;
                    state  <= RUN;
                end
                default: ;
            endcase
        end

        // LFSR and display scan run regardless of game state.
        if (!i_Rst) begin
            lfsr  <= 16'hACE1;
            row   <= '0;
            row_q <= ROW_ONE;
            col_q <= '0;
        end else begin
            lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            row   <= row + YW'(1);
            row_q <= ROW_ONE << row;
            col_q <= col_c;
        end
    end

    assign bus.o_Row      = row_q;
    assign bus.o_Col      = col_q;
    assign bus.o_Score    = score;
    assign bus.o_Len      = len;
    assign bus.o_State    = state;
    assign bus.o_GameOver = over_q;
endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: 8x8 grid, MAX_LEN 8, TICK_DIV 4, SCORE_W 7.
module tb_snake_engine;
    localparam int unsigned GW = 8, GH = 8, ML = 8, TD = 4, SW = 7, LW = 4;

    logic clk;
    logic rst_n;
    int   n_vec = 0;
    int   n_bad = 0;

    snake_engine_if #(.GRID_W(GW), .GRID_H(GH), .SCORE_W(SW), .LEN_W(LW)) bus ();

    snake_engine #(.GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .TICK_DIV(TD), .SCORE_W(SW))
        dut (.i_Clk(clk), .i_Rst(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_quiet();
        for (int k = 0; k < 10 && dut.tick_c; k++) @(negedge clk);
    endtask

    // Hold a button pattern and return just after the next snake move.
    task automatic tick_wait(input logic [3:0] push);
        logic seen;
        seen = 1'b0;
        wait_quiet();
        bus.i_Push = push;
        @(negedge clk);
        for (int k = 0; k < 4 * TD && !seen; k++) begin
            if (dut.tick_c) seen = 1'b1;
            @(negedge clk);
        end
        check("tick_seen", 32'(seen), 1);
    endtask

    task automatic wait_state(input string tag, input logic [1:0] s);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            if (bus.o_State == s) ok = 1'b1;
            else @(negedge clk);
        end
        check(tag, 32'(ok), 1);
    endtask

    task automatic wait_row(input logic [7:0] r);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            if (bus.o_Row == r) ok = 1'b1;
            else @(negedge clk);
        end
        check("row_found", 32'(ok), 1);
    endtask

    task automatic pulse_start();
        bus.i_Start = 1'b1;
        @(negedge clk);
        bus.i_Start = 1'b0;
    endtask

    task automatic head_is(input string tag, input int x, input int y);
        check({tag, "_x"}, 32'(dut.seg_x[0]), 32'(x));
        check({tag, "_y"}, 32'(dut.seg_y[0]), 32'(y));
    endtask

    initial begin
        logic onseg;
        rst_n       = 1'b0;
        bus.i_Start = 1'b0;
        bus.i_Push  = 4'hF;
        repeat (2) @(negedge clk);
        check("rst_state", 32'(bus.o_State), 0);
        check("rst_row", 32'(bus.o_Row), 32'h01);
        check("rst_col", 32'(bus.o_Col), 0);
        check("rst_len", 32'(bus.o_Len), 3);
        check("rst_score", 32'(bus.o_Score), 0);
        check("rst_over", 32'(bus.o_GameOver), 0);
        head_is("rst_head", 2, 0);
        rst_n = 1'b1;

        // Display scan of the default snake and food while idle.
        @(negedge clk);
        wait_row(8'h01);
        check("scan_row0", 32'(bus.o_Col), 32'h07);
        wait_row(8'h40);
        check("scan_row6", 32'(bus.o_Col), 32'h40);
        check("idle_state", 32'(bus.o_State), 0);

        pulse_start();
        check("start_state", 32'(bus.o_State), 1);
        repeat (4) @(negedge clk);
        head_is("tick1", 3, 0);
        check("tick1_len", 32'(bus.o_Len), 3);
        check("tick1_score", 32'(bus.o_Score), 0);

        // Run into the right wall.
        repeat (4) tick_wait(4'hF);
        head_is("tick5", 7, 0);
        tick_wait(4'hF);
`ifdef SNAKE_WRAP_EN
        head_is("wrap", 0, 0);
        check("wrap_state", 32'(bus.o_State), 1);
        check("wrap_over", 32'(bus.o_GameOver), 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_state", 32'(bus.o_State), 0);
        head_is("midrst_head", 2, 0);
        rst_n = 1'b1;
        pulse_start();
`else
        check("wall_state", 32'(bus.o_State), 3);
        check("wall_over", 32'(bus.o_GameOver), 1);
        head_is("wall_frozen", 7, 0);
        pulse_start();
`endif
        check("restart_state", 32'(bus.o_State), 1);
        check("restart_over", 32'(bus.o_GameOver), 0);
        check("restart_score", 32'(bus.o_Score), 0);
        head_is("restart_head", 2, 0);

        // Reversal is filtered; a perpendicular press turns on the next tick.
        tick_wait(4'b1011);
        head_is("rev_left", 3, 0);
        tick_wait(4'b1101);
        head_is("turn_down", 3, 1);
        bus.i_Push = 4'hF;

        // Eat: food placed directly in front of a fresh snake.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dut.food_x = 3'd3;
        dut.food_y = 3'd0;
        pulse_start();
        tick_wait(4'hF);
        check("eat_score", 32'(bus.o_Score), 1);
        check("eat_len", 32'(bus.o_Len), 4);
        check("eat_state", 32'(bus.o_State), 2);
        wait_state("food_to_run", 2'd1);
        onseg = 1'b0;
        for (int i = 0; i < 4; i++)
            if (dut.seg_x[i] == dut.food_x && dut.seg_y[i] == dut.food_y) onseg = 1'b1;
        check("food_free", 32'(onseg), 0);

        // Length-5 snake turns down, left, up into its own body.
        wait_quiet();
        for (int i = 0; i < 5; i++) begin
            dut.seg_x[i] = 3'(4 - i);
            dut.seg_y[i] = 3'd0;
        end
        dut.len    = 4'd5;
        dut.food_x = 3'd7;
        dut.food_y = 3'd7;
        tick_wait(4'b1101);
        head_is("col_down", 4, 1);
        tick_wait(4'b1011);
        tick_wait(4'b1110);
        check("col_state", 32'(bus.o_State), 3);
        check("col_over", 32'(bus.o_GameOver), 1);
        check("col_len", 32'(bus.o_Len), 5);
        head_is("col_head", 3, 1);
        bus.i_Push = 4'hF;
        repeat (10) @(negedge clk);
        head_is("col_frozen", 3, 1);
        check("col_hold", 32'(bus.o_State), 3);

        // Full-length snake eats twice: length capped, score saturates.
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            dut.seg_x[i] = 3'(7 - i);
            dut.seg_y[i] = 3'd0;
        end
        dut.len    = 4'd8;
        dut.dir    = 2'd1;
        dut.pend   = 2'd1;
        dut.food_x = 3'd7;
        dut.food_y = 3'd1;
        dut.score  = 7'd126;
        tick_wait(4'hF);
        check("max_len", 32'(bus.o_Len), 8);
        check("max_score", 32'(bus.o_Score), 127);
        check("max_state", 32'(bus.o_State), 2);
        head_is("max_head", 7, 1);
        wait_state("max_to_run", 2'd1);
        wait_quiet();
        dut.food_x = 3'd7;
        dut.food_y = 3'd2;
        tick_wait(4'hF);
        check("sat_score", 32'(bus.o_Score), 127);
        check("sat_len", 32'(bus.o_Len), 8);
        head_is("sat_head", 7, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
